// File: rtl/panda_risc_v_dispatch_queue.sv
// panda_risc_v_dispatch_queue: in-order dispatch queue that issues the oldest request to one of exu_num channels.
// Latency: 1 cycle from push to issue; 0 cycles from an empty queue when PANDA_DSPTC_QUEUE_BYPASS_EN is defined.
// Backpressure: s_dsptc_ready drops only when full, flushing or in reset; the head waits on per-channel ready or hazards.
//
// Ports:
//   clk, sys_reset (sync, active-high), flush_req  - clock, reset, discard all queued entries
//   lsu_idle                                        - LSU idle flag used by barrier entries
//   s_dsptc_*                                       - incoming decoded request (valid/ready)
//   waw_dpc_check_rd_id / rd_waw_dpc                - head RD index out, WAW hazard flag back
//   m_exu_*                                         - head payload shared by all channels, per-channel valid/ready
//   dpc_trace_dsptc_*                               - pulse + ID of the issued instruction
//   queue_cnt                                       - occupancy
// Optional macro: PANDA_DSPTC_QUEUE_BYPASS_EN (empty-queue combinational bypass).
// simulation_delay is kept for interface compatibility; state updates carry no delay.

module panda_risc_v_dispatch_queue #(
   parameter int inst_id_width    = 4,
   parameter int msg_width        = 71,
   parameter int exu_num          = 5,
   parameter int fifo_depth       = 4,
   parameter int simulation_delay = 1
) (
   input  logic                         clk,
   input  logic                         sys_reset,
   input  logic                         flush_req,
   input  logic                         lsu_idle,
   input  logic [msg_width-1:0]         s_dsptc_msg,
   input  logic [exu_num-1:0]           s_dsptc_exu_sel,
   input  logic [4:0]                   s_dsptc_rd_id,
   input  logic                         s_dsptc_rd_vld,
   input  logic                         s_dsptc_wait_idle,
   input  logic [inst_id_width-1:0]     s_dsptc_inst_id,
   input  logic                         s_dsptc_valid,
   output logic                         s_dsptc_ready,
   output logic [4:0]                   waw_dpc_check_rd_id,
   input  logic                         rd_waw_dpc,
   output logic [msg_width-1:0]         m_exu_msg,
   output logic [4:0]                   m_exu_rd_id,
   output logic [inst_id_width-1:0]     m_exu_inst_id,
   output logic [exu_num-1:0]           m_exu_valid,
   input  logic [exu_num-1:0]           m_exu_ready,
   output logic [inst_id_width-1:0]     dpc_trace_dsptc_inst_id,
   output logic                         dpc_trace_dsptc_valid,
   output logic [$clog2(fifo_depth):0]  queue_cnt
);

   localparam int AW = $clog2(fifo_depth);
   localparam logic [AW:0] PTR_ONE = 1;
   // Holds for every legal parameter set; an illegal set leaves the queue refusing input.
   localparam bit PARAM_OK = (exu_num >= 1) && (exu_num <= 8) && (fifo_depth >= 2) &&
                             (simulation_delay >= 0);

   typedef struct packed {
      logic [msg_width-1:0]     msg;
      logic [exu_num-1:0]       sel;
      logic [4:0]               rd_id;
      logic                     rd_vld;
      logic                     wait_idle;
      logic [inst_id_width-1:0] inst_id;
   } entry_t;

   entry_t            mem_q [fifo_depth];
   entry_t            mem_d [fifo_depth];
   logic [AW:0]       wptr_q, wptr_d;
   logic [AW:0]       rptr_q, rptr_d;

   entry_t            in_ent;
   entry_t            head_ent;
   logic              head_pres;
   logic              bypass;
   logic              full, empty;
   logic              head_ok;
   logic [exu_num-1:0] sel_low;
   logic              issue, fire;
   logic              push_buf, pop_buf;

   assign in_ent = {s_dsptc_msg, s_dsptc_exu_sel, s_dsptc_rd_id, s_dsptc_rd_vld,
                    s_dsptc_wait_idle, s_dsptc_inst_id};

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

`ifdef PANDA_DSPTC_QUEUE_BYPASS_EN
   // An empty queue lets the incoming request act as the head in the same cycle.
   assign bypass    = empty & ~flush_req;
   assign head_ent  = bypass ? in_ent : mem_q[rptr_q[AW-1:0]];
   assign head_pres = bypass ? s_dsptc_valid : ~empty;
`else
   assign bypass    = 1'b0;
   assign head_ent  = mem_q[rptr_q[AW-1:0]];
   assign head_pres = ~empty;
`endif

   assign head_ok = head_pres & ~(head_ent.rd_vld & rd_waw_dpc) &
                    ~(head_ent.wait_idle & ~lsu_idle) & ~flush_req & ~sys_reset;

   // Lowest set bit of the head select; descending scan so the lowest index wins.
   always_comb begin
      sel_low = '0;
      for (int k = exu_num - 1; k >= 0; k--) begin
         if (head_ent.sel[k]) begin
            sel_low    = '0;
            sel_low[k] = 1'b1;
         end
      end
   end

   assign m_exu_valid = head_ok ? sel_low : '0;
   assign issue       = |(m_exu_valid & m_exu_ready);
   // An all-zero select has no channel to wait for and is retired silently.
   assign fire        = issue | (head_ok & ~(|head_ent.sel));

   assign s_dsptc_ready = PARAM_OK & ~full & ~flush_req & ~sys_reset;
   // A bypassed request consumed this cycle must not also land in the buffer.
   assign push_buf      = s_dsptc_valid & s_dsptc_ready & ~(bypass & fire);
   assign pop_buf       = fire & ~bypass;

   assign m_exu_msg               = head_ent.msg;
   assign m_exu_rd_id             = head_ent.rd_id;
   assign m_exu_inst_id           = head_ent.inst_id;
   assign waw_dpc_check_rd_id     = head_pres ? head_ent.rd_id : 5'd0;
   assign dpc_trace_dsptc_valid   = issue;
   assign dpc_trace_dsptc_inst_id = head_ent.inst_id;
   assign queue_cnt               = wptr_q - rptr_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      mem_d  = mem_q;
      if (sys_reset || flush_req) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_buf) begin
            mem_d[wptr_q[AW-1:0]] = in_ent;
            wptr_d                = wptr_q + PTR_ONE;
         end
         if (pop_buf) begin
            rptr_d = rptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Payload storage needs no reset: pointers decide which slots are meaningful.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_panda_risc_v_dispatch_queue.sv
module tb_panda_risc_v_dispatch_queue;

   localparam int EXU   = 5;
   localparam int IDW   = 4;
   localparam int MSGW  = 71;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            sys_reset, flush_req, lsu_idle;
   logic [MSGW-1:0] s_dsptc_msg;
   logic [EXU-1:0]  s_dsptc_exu_sel;
   logic [4:0]      s_dsptc_rd_id;
   logic            s_dsptc_rd_vld, s_dsptc_wait_idle;
   logic [IDW-1:0]  s_dsptc_inst_id;
   logic            s_dsptc_valid, s_dsptc_ready;
   logic [4:0]      waw_dpc_check_rd_id;
   logic            rd_waw_dpc;
   logic [MSGW-1:0] m_exu_msg;
   logic [4:0]      m_exu_rd_id;
   logic [IDW-1:0]  m_exu_inst_id;
   logic [EXU-1:0]  m_exu_valid, m_exu_ready;
   logic [IDW-1:0]  dpc_trace_dsptc_inst_id;
   logic            dpc_trace_dsptc_valid;
   logic [2:0]      queue_cnt;

   panda_risc_v_dispatch_queue #(
      .inst_id_width(IDW), .msg_width(MSGW), .exu_num(EXU),
      .fifo_depth(DEPTH), .simulation_delay(1)
   ) dut (
      .clk(clk), .sys_reset(sys_reset), .flush_req(flush_req), .lsu_idle(lsu_idle),
      .s_dsptc_msg(s_dsptc_msg), .s_dsptc_exu_sel(s_dsptc_exu_sel),
      .s_dsptc_rd_id(s_dsptc_rd_id), .s_dsptc_rd_vld(s_dsptc_rd_vld),
      .s_dsptc_wait_idle(s_dsptc_wait_idle), .s_dsptc_inst_id(s_dsptc_inst_id),
      .s_dsptc_valid(s_dsptc_valid), .s_dsptc_ready(s_dsptc_ready),
      .waw_dpc_check_rd_id(waw_dpc_check_rd_id), .rd_waw_dpc(rd_waw_dpc),
      .m_exu_msg(m_exu_msg), .m_exu_rd_id(m_exu_rd_id), .m_exu_inst_id(m_exu_inst_id),
      .m_exu_valid(m_exu_valid), .m_exu_ready(m_exu_ready),
      .dpc_trace_dsptc_inst_id(dpc_trace_dsptc_inst_id),
      .dpc_trace_dsptc_valid(dpc_trace_dsptc_valid), .queue_cnt(queue_cnt)
   );

   // Reference model: a plain queue of requests, oldest at index 0.
   typedef struct packed {
      logic [MSGW-1:0] msg;
      logic [EXU-1:0]  sel;
      logic [4:0]      rd;
      logic            rdv;
      logic            wi;
      logic [IDW-1:0]  id;
   } ent_t;

   ent_t mq[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic ent_t cur_in();
      ent_t e;
      e.msg = s_dsptc_msg;   e.sel = s_dsptc_exu_sel; e.rd = s_dsptc_rd_id;
      e.rdv = s_dsptc_rd_vld; e.wi = s_dsptc_wait_idle; e.id = s_dsptc_inst_id;
      return e;
   endfunction

   function automatic bit m_byp();
`ifdef PANDA_DSPTC_QUEUE_BYPASS_EN
      return (mq.size() == 0) && !flush_req;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_pres();
      if (m_byp()) return s_dsptc_valid;
      return mq.size() > 0;
   endfunction

   function automatic ent_t m_head();
      if (m_byp()) return cur_in();
      if (mq.size() > 0) return mq[0];
      return '0;
   endfunction

   function automatic bit m_ok();
      ent_t h = m_head();
      return m_pres() && !(h.rdv && rd_waw_dpc) && !(h.wi && !lsu_idle) && !flush_req && !sys_reset;
   endfunction

   function automatic logic [EXU-1:0] m_valid();
      ent_t h = m_head();
      if (!m_ok()) return '0;
      for (int k = 0; k < EXU; k++)
         if (h.sel[k]) return EXU'(1 << k);
      return '0;
   endfunction

   function automatic bit m_issue();
      return (m_valid() & m_exu_ready) != '0;
   endfunction

   function automatic bit m_fire();
      return m_issue() || (m_ok() && m_head().sel == '0);
   endfunction

   function automatic bit m_ready();
      return (mq.size() < DEPTH) && !flush_req && !sys_reset;
   endfunction

   // Advance one clock and apply the spec's queue rules to the model.
   task automatic tick();
      bit   f   = m_fire();
      bit   b   = m_byp();
      bit   acc = s_dsptc_valid && m_ready();
      bit   clr = sys_reset || flush_req;
      ent_t in  = cur_in();
      @(posedge clk);
      if (clr) mq.delete();
      else begin
         if (f && !b) void'(mq.pop_front());
         if (acc && !(b && f)) mq.push_back(in);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      s_dsptc_valid = 1'b0; flush_req = 1'b0; rd_waw_dpc = 1'b0;
      lsu_idle = 1'b1; m_exu_ready = '1; sys_reset = 1'b0;
      s_dsptc_rd_vld = 1'b0; s_dsptc_wait_idle = 1'b0;
   endtask

   task automatic drive(input logic [EXU-1:0] sel, input logic [IDW-1:0] id,
                        input logic rdv, input logic [4:0] rd, input logic wi);
      s_dsptc_valid = 1'b1; s_dsptc_exu_sel = sel; s_dsptc_inst_id = id;
      s_dsptc_rd_vld = rdv; s_dsptc_rd_id = rd; s_dsptc_wait_idle = wi;
      s_dsptc_msg = MSGW'({$urandom(), $urandom(), $urandom()});
   endtask

   task automatic test_reset();
      idle();
      sys_reset = 1'b1;
      s_dsptc_valid = 1'b1; s_dsptc_exu_sel = 5'b00001; s_dsptc_inst_id = '0;
      s_dsptc_rd_id = '0; s_dsptc_msg = '0;
      tick();
      #1;
      n_run++; if (m_exu_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", m_exu_valid); end
      n_run++; if (s_dsptc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", s_dsptc_ready); end
      n_run++; if (dpc_trace_dsptc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trace: got %b exp 0", dpc_trace_dsptc_valid); end
      tick();
      idle();
      #1;
      n_run++; if (queue_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", queue_cnt); end
      n_run++; if (s_dsptc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b exp 1", s_dsptc_ready); end
   endtask

   task automatic test_order();
      logic [EXU-1:0] sels [4] = '{5'b00001, 5'b00100, 5'b10000, 5'b00010};
      int             chans[4] = '{0, 2, 4, 1};
      int             got_id[$];
      int             got_ch[$];
      idle();
      for (int c = 0; c < 12; c++) begin
         if (c < 4) drive(sels[c], IDW'(c), 1'b0, 5'd0, 1'b0);
         else s_dsptc_valid = 1'b0;
         #1;
         n_run++; if (m_exu_valid !== m_valid()) begin n_fail++; $display("FAIL order_valid c%0d: got %b exp %b", c, m_exu_valid, m_valid()); end
         if (dpc_trace_dsptc_valid === 1'b1) begin
            got_id.push_back(int'(dpc_trace_dsptc_inst_id));
            for (int k = 0; k < EXU; k++) if (m_exu_valid[k]) got_ch.push_back(k);
         end
         tick();
      end
      #1;
      n_run++; if (got_id.size() != 4 || got_ch.size() != 4) begin n_fail++; $display("FAIL order_count: got %0d/%0d exp 4", got_id.size(), got_ch.size()); end
      for (int i = 0; i < 4 && i < got_id.size() && i < got_ch.size(); i++) begin
         n_run++; if (got_id[i] != i || got_ch[i] != chans[i]) begin n_fail++; $display("FAIL order_issue%0d: got id %0d ch %0d exp id %0d ch %0d", i, got_id[i], got_ch[i], i, chans[i]); end
      end
      n_run++; if (queue_cnt !== 3'd0) begin n_fail++; $display("FAIL order_cnt: got %0d exp 0", queue_cnt); end
   endtask

   task automatic test_full();
      int             acc = 0;
      int             got[$];
      logic [EXU-1:0] one = 5'b00001;
      idle();
      m_exu_ready = '0;
      for (int c = 0; c < 5; c++) begin
         drive(one << $urandom_range(0, EXU - 1), IDW'(acc), 1'b0, 5'd0, 1'b0);
         #1;
         n_run++; if (s_dsptc_ready !== m_ready()) begin n_fail++; $display("FAIL full_ready c%0d: got %b exp %b", c, s_dsptc_ready, m_ready()); end
         if (m_ready()) acc++;
         tick();
      end
      s_dsptc_valid = 1'b0;
      #1;
      n_run++; if (queue_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt: got %0d exp 4", queue_cnt); end
      n_run++; if (s_dsptc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b exp 0", s_dsptc_ready); end
      m_exu_ready = '1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_run++; if (dpc_trace_dsptc_valid !== 1'b1 || dpc_trace_dsptc_inst_id !== IDW'(k)) begin n_fail++; $display("FAIL full_drain%0d: got v%b id %0d exp v1 id %0d", k, dpc_trace_dsptc_valid, dpc_trace_dsptc_inst_id, k); end
         tick();
      end
      for (int c = 0; c < 9; c++) begin
         if (c < 6) drive(one << $urandom_range(0, EXU - 1), IDW'(10 + c), 1'b0, 5'd0, 1'b0);
         else s_dsptc_valid = 1'b0;
         #1;
         n_run++; if (dpc_trace_dsptc_valid !== m_issue()) begin n_fail++; $display("FAIL wrap_trace c%0d: got %b exp %b", c, dpc_trace_dsptc_valid, m_issue()); end
         if (dpc_trace_dsptc_valid === 1'b1) got.push_back(int'(dpc_trace_dsptc_inst_id));
         tick();
      end
      n_run++; if (got.size() != 6) begin n_fail++; $display("FAIL wrap_count: got %0d exp 6", got.size()); end
      for (int i = 0; i < got.size() && i < 6; i++) begin
         n_run++; if (got[i] != 10 + i) begin n_fail++; $display("FAIL wrap_id%0d: got %0d exp %0d", i, got[i], 10 + i); end
      end
   endtask

   task automatic test_waw();
      idle();
      rd_waw_dpc = 1'b1;
      drive(5'b00100, 4'd5, 1'b1, 5'd7, 1'b0);
      tick();
      s_dsptc_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_run++; if (waw_dpc_check_rd_id !== 5'd7 || m_exu_valid !== '0) begin n_fail++; $display("FAIL waw_stall%0d: got rd %0d v %b exp rd 7 v 0", c, waw_dpc_check_rd_id, m_exu_valid); end
         tick();
      end
      rd_waw_dpc = 1'b0;
      #1;
      n_run++; if (m_exu_valid !== 5'b00100 || dpc_trace_dsptc_valid !== 1'b1 || dpc_trace_dsptc_inst_id !== 4'd5) begin n_fail++; $display("FAIL waw_issue: got v %b t %b id %0d exp v 00100 t 1 id 5", m_exu_valid, dpc_trace_dsptc_valid, dpc_trace_dsptc_inst_id); end
      tick();
      #1;
      n_run++; if (waw_dpc_check_rd_id !== 5'd0 || queue_cnt !== 3'd0) begin n_fail++; $display("FAIL waw_empty: got rd %0d cnt %0d exp 0 0", waw_dpc_check_rd_id, queue_cnt); end
   endtask

   task automatic test_barrier();
      idle();
      lsu_idle = 1'b0;
      drive(5'b01000, 4'd3, 1'b0, 5'd0, 1'b1);
      tick();
      s_dsptc_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_run++; if (m_exu_valid !== '0) begin n_fail++; $display("FAIL barrier_hold%0d: got %b exp 0", c, m_exu_valid); end
         tick();
      end
      lsu_idle = 1'b1;
      #1;
      n_run++; if (m_exu_valid !== 5'b01000 || dpc_trace_dsptc_inst_id !== 4'd3) begin n_fail++; $display("FAIL barrier_issue: got v %b id %0d exp v 01000 id 3", m_exu_valid, dpc_trace_dsptc_inst_id); end
      tick();
      drive(5'b00000, 4'd10, 1'b0, 5'd0, 1'b0);
      tick();
      s_dsptc_valid = 1'b0;
      #1;
      n_run++; if (m_exu_valid !== '0 || dpc_trace_dsptc_valid !== 1'b0) begin n_fail++; $display("FAIL drop_quiet: got v %b t %b exp 0 0", m_exu_valid, dpc_trace_dsptc_valid); end
      tick();
      #1;
      n_run++; if (queue_cnt !== 3'd0) begin n_fail++; $display("FAIL drop_cnt: got %0d exp 0", queue_cnt); end
   endtask

   task automatic test_flush();
      idle();
      m_exu_ready = '0;
      for (int c = 0; c < 3; c++) begin
         drive(5'b00010, IDW'(c + 1), 1'b0, 5'd0, 1'b0);
         tick();
      end
      #1;
      n_run++; if (queue_cnt !== 3'd3) begin n_fail++; $display("FAIL flush_pre_cnt: got %0d exp 3", queue_cnt); end
      flush_req = 1'b1;
      m_exu_ready = '1;
      drive(5'b00010, 4'd4, 1'b0, 5'd0, 1'b0);
      #1;
      n_run++; if (s_dsptc_ready !== 1'b0 || dpc_trace_dsptc_valid !== 1'b0 || m_exu_valid !== '0) begin n_fail++; $display("FAIL flush_cycle: got r %b t %b v %b exp 0 0 0", s_dsptc_ready, dpc_trace_dsptc_valid, m_exu_valid); end
      tick();
      flush_req = 1'b0;
      s_dsptc_valid = 1'b0;
      #1;
      n_run++; if (queue_cnt !== 3'd0 || s_dsptc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got cnt %0d r %b exp 0 1", queue_cnt, s_dsptc_ready); end
      tick();
      #1;
      n_run++; if (dpc_trace_dsptc_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got %b exp 0", dpc_trace_dsptc_valid); end
   endtask

   task automatic test_latency();
      idle();
      drive(5'b01000, 4'd9, 1'b0, 5'd0, 1'b0);
      #1;
`ifdef PANDA_DSPTC_QUEUE_BYPASS_EN
      n_run++; if (m_exu_valid !== 5'b01000 || dpc_trace_dsptc_valid !== 1'b1 || dpc_trace_dsptc_inst_id !== 4'd9) begin n_fail++; $display("FAIL bypass_issue: got v %b t %b id %0d exp 01000 1 9", m_exu_valid, dpc_trace_dsptc_valid, dpc_trace_dsptc_inst_id); end
`else
      n_run++; if (m_exu_valid !== '0) begin n_fail++; $display("FAIL latency_same: got %b exp 0", m_exu_valid); end
`endif
      tick();
      s_dsptc_valid = 1'b0;
      #1;
`ifdef PANDA_DSPTC_QUEUE_BYPASS_EN
      n_run++; if (queue_cnt !== 3'd0 || m_exu_valid !== '0) begin n_fail++; $display("FAIL bypass_after: got cnt %0d v %b exp 0 0", queue_cnt, m_exu_valid); end
`else
      n_run++; if (m_exu_valid !== 5'b01000 || dpc_trace_dsptc_inst_id !== 4'd9) begin n_fail++; $display("FAIL latency_next: got v %b id %0d exp 01000 9", m_exu_valid, dpc_trace_dsptc_inst_id); end
`endif
      tick();
   endtask

   task automatic test_random();
      ent_t h;
      idle();
      for (int c = 0; c < 600; c++) begin
         sys_reset   = ($urandom_range(0, 99) == 0);
         flush_req   = ($urandom_range(0, 39) == 0);
         lsu_idle    = ($urandom_range(0, 3) != 0);
         rd_waw_dpc  = ($urandom_range(0, 3) == 0);
         m_exu_ready = EXU'($urandom());
         if ($urandom_range(0, 1) == 1)
            drive(EXU'($urandom()), IDW'($urandom()), 1'($urandom()), 5'($urandom()), ($urandom_range(0, 4) == 0));
         else
            s_dsptc_valid = 1'b0;
         #1;
         h = m_head();
         n_run++; if (s_dsptc_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, s_dsptc_ready, m_ready()); end
         n_run++; if (m_exu_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, m_exu_valid, m_valid()); end
         n_run++; if (dpc_trace_dsptc_valid !== m_issue()) begin n_fail++; $display("FAIL rnd_trace c%0d: got %b exp %b", c, dpc_trace_dsptc_valid, m_issue()); end
         n_run++; if (queue_cnt !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, queue_cnt, mq.size()); end
         n_run++; if (waw_dpc_check_rd_id !== (m_pres() ? h.rd : 5'd0)) begin n_fail++; $display("FAIL rnd_waw c%0d: got %0d exp %0d", c, waw_dpc_check_rd_id, m_pres() ? h.rd : 5'd0); end
         if (m_pres()) begin
            n_run++; if (m_exu_msg !== h.msg || m_exu_inst_id !== h.id || m_exu_rd_id !== h.rd) begin n_fail++; $display("FAIL rnd_head c%0d: got id %0d rd %0d msg %h exp id %0d rd %0d msg %h", c, m_exu_inst_id, m_exu_rd_id, m_exu_msg, h.id, h.rd, h.msg); end
         end
         if (m_issue()) begin
            n_run++; if (dpc_trace_dsptc_inst_id !== h.id) begin n_fail++; $display("FAIL rnd_trace_id c%0d: got %0d exp %0d", c, dpc_trace_dsptc_inst_id, h.id); end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      s_dsptc_msg = '0; s_dsptc_exu_sel = '0; s_dsptc_rd_id = '0; s_dsptc_inst_id = '0;
      test_reset();
      test_order();
      test_full();
      test_waw();
      test_barrier();
      test_flush();
      test_latency();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
